// File: rtl/pcie_hip_app_rst_ctrl.sv
// Application reset responder for the Stratix IV PCIe hard IP: debounced release on link-up,
// quiesce handshake plus timed hold on link faults. Optional quiesce stage: PCIE_APP_RST_QUIESCE_EN.
module pcie_hip_app_rst_ctrl #(
    parameter int LINKUP_DEBOUNCE = 16,
    parameter int QUIESCE_TIMEOUT = 4096,
    parameter int RST_HOLD        = 64
) (
    input  logic       pld_clk,
    input  logic       srst,
    input  logic       app_rstn,
    input  logic [4:0] ltssm,
    input  logic       dl_up,
    input  logic       quiesce_ack,
    output logic       usr_rst,
    output logic       quiesce_req,
    output logic       link_up,
    output logic [1:0] rst_cause,
    output logic [7:0] rst_count
);

    localparam int MAX_A = (LINKUP_DEBOUNCE > RST_HOLD) ? LINKUP_DEBOUNCE : RST_HOLD;
    localparam int MAX_C = (MAX_A > QUIESCE_TIMEOUT) ? MAX_A : QUIESCE_TIMEOUT;
    localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(LINKUP_DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);
    localparam logic [4:0]       LTSSM_L0    = 5'h0F;
    localparam logic [4:0]       LTSSM_FAULT = 5'h10;

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT_LINK,
        S_DEBOUNCE,
        S_UP,
`ifdef PCIE_APP_RST_QUIESCE_EN
        S_QUIESCE,
`endif
        S_HOLD
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             cnt_inc;
    logic [1:0]       cause_nxt;
    logic [7:0]       count_nxt;

    logic             app_rstn_r, dl_up_r;
    logic [4:0]       ltssm_r;
    logic             ok, fault;

    always_ff @(posedge pld_clk) begin
        if (srst) begin
            app_rstn_r <= 1'b0;
            dl_up_r    <= 1'b0;
            ltssm_r    <= 5'h00;
        end else begin
            app_rstn_r <= app_rstn;
            dl_up_r    <= dl_up;
            ltssm_r    <= ltssm;
        end
    end

`ifdef PCIE_APP_RST_QUIESCE_EN
    localparam logic [CNT_W-1:0] QT_LAST = CNT_W'(QUIESCE_TIMEOUT - 1);
    logic quiesce_ack_r;

    always_ff @(posedge pld_clk) begin
        if (srst) quiesce_ack_r <= 1'b0;
        else      quiesce_ack_r <= quiesce_ack;
    end
`else
    logic unused_quiesce_ack;
    assign unused_quiesce_ack = quiesce_ack;
`endif

    assign ok    = dl_up_r && (ltssm_r == LTSSM_L0);
    assign fault = !app_rstn_r || !dl_up_r || (ltssm_r == LTSSM_FAULT);

    always_ff @(posedge pld_clk) begin
        if (srst) begin
            state     <= S_RESET;
            cnt       <= '0;
            rst_cause <= 2'b00;
            rst_count <= 8'h00;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rst_cause <= cause_nxt;
            rst_count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_inc     = 1'b0;
        cause_nxt   = rst_cause;
        count_nxt   = rst_count;
        usr_rst     = 1'b1;
        quiesce_req = 1'b0;
        link_up     = 1'b0;

        case (state)
            S_RESET: begin
                if (app_rstn_r) state_nxt = S_WAIT_LINK;
            end
            S_WAIT_LINK: begin
                if (!app_rstn_r) state_nxt = S_RESET;
                else if (ok)     state_nxt = S_DEBOUNCE;
            end
            S_DEBOUNCE: begin
                // ok dropping on the terminal count still wins over release
                if (!app_rstn_r)          state_nxt = S_RESET;
                else if (!ok)             state_nxt = S_WAIT_LINK;
                else if (cnt == DEB_LAST) state_nxt = S_UP;
                else                      cnt_inc   = 1'b1;
            end
            S_UP: begin
                usr_rst = 1'b0;
                link_up = 1'b1;
                if (fault) begin
`ifdef PCIE_APP_RST_QUIESCE_EN
                    state_nxt = S_QUIESCE;
`else
                    state_nxt = S_HOLD;
`endif
                    cause_nxt = app_rstn_r ? 2'b10 : 2'b01;
                    count_nxt = (rst_count == 8'hFF) ? rst_count : rst_count + 8'd1;
                end
            end
`ifdef PCIE_APP_RST_QUIESCE_EN
            S_QUIESCE: begin
                usr_rst     = 1'b0;
                quiesce_req = 1'b1;
                // ack is checked first so a same-edge timeout keeps the latched cause
                if (!app_rstn_r || quiesce_ack_r) state_nxt = S_HOLD;
                else if (cnt == QT_LAST) begin
                    state_nxt = S_HOLD;
                    cause_nxt = 2'b11;
                end else cnt_inc = 1'b1;
            end
`endif
            S_HOLD: begin
                if (cnt == HOLD_LAST) state_nxt = S_WAIT_LINK;
                else                  cnt_inc   = 1'b1;
            end
            default: state_nxt = S_RESET;
        endcase

        if (state_nxt != state) cnt_nxt = '0;
        else if (cnt_inc)       cnt_nxt = cnt + CNT_W'(1);
        else                    cnt_nxt = cnt;
    end

endmodule

// File: tb/tb_pcie_hip_app_rst_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed output-change events, a monitor pops them
// whenever the observed output tuple changes. A second small-parameter instance covers saturation.
module tb_pcie_hip_app_rst_ctrl;

    logic       pld_clk = 1'b0;
    logic       srst, app_rstn, dl_up, quiesce_ack;
    logic [4:0] ltssm;
    logic       usr_rst, quiesce_req, link_up;
    logic [1:0] rst_cause;
    logic [7:0] rst_count;

    logic       s_srst, s_app_rstn, s_dl_up, s_quiesce_ack;
    logic [4:0] s_ltssm;
    logic       s_usr_rst, s_quiesce_req, s_link_up;
    logic [1:0] s_rst_cause;
    logic [7:0] s_rst_count;

    always #5 pld_clk = ~pld_clk;

    pcie_hip_app_rst_ctrl #(.LINKUP_DEBOUNCE(16), .QUIESCE_TIMEOUT(4096), .RST_HOLD(64)) dut (
        .pld_clk(pld_clk), .srst(srst), .app_rstn(app_rstn), .ltssm(ltssm), .dl_up(dl_up),
        .quiesce_ack(quiesce_ack), .usr_rst(usr_rst), .quiesce_req(quiesce_req),
        .link_up(link_up), .rst_cause(rst_cause), .rst_count(rst_count)
    );

    pcie_hip_app_rst_ctrl #(.LINKUP_DEBOUNCE(1), .QUIESCE_TIMEOUT(2), .RST_HOLD(1)) dut_s (
        .pld_clk(pld_clk), .srst(s_srst), .app_rstn(s_app_rstn), .ltssm(s_ltssm), .dl_up(s_dl_up),
        .quiesce_ack(s_quiesce_ack), .usr_rst(s_usr_rst), .quiesce_req(s_quiesce_req),
        .link_up(s_link_up), .rst_cause(s_rst_cause), .rst_count(s_rst_count)
    );

    typedef struct {
        int         cyc;
        logic       u;
        logic       l;
        logic       q;
        logic [1:0] c;
        logic [7:0] n;
    } ev_t;

    ev_t  exp_q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;
    bit   s_q_seen = 1'b0;

`ifdef PCIE_APP_RST_QUIESCE_EN
    localparam logic [1:0] RSTN_CAUSE = 2'b10;
    localparam logic [1:0] SAT_CAUSE  = 2'b11;
    localparam int         SAT_QSEEN  = 1;
`else
    localparam logic [1:0] RSTN_CAUSE = 2'b01;
    localparam logic [1:0] SAT_CAUSE  = 2'b10;
    localparam int         SAT_QSEEN  = 0;
`endif

    always @(posedge pld_clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic u, input logic l, input logic q,
                        input logic [1:0] ca, input logic [7:0] n);
        ev_t e;
        e.cyc = c; e.u = u; e.l = l; e.q = q; e.c = ca; e.n = n;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge pld_clk);
    endtask

    task automatic tick_to(input int c);
        while (cyc < c) @(negedge pld_clk);
    endtask

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // Monitor: every change of the output tuple must match the next queued event.
    initial begin
        logic [12:0] prev, obs;
        ev_t         e;
        prev = 'x;
        forever begin
            @(negedge pld_clk);
            obs = {usr_rst, link_up, quiesce_req, rst_cause, rst_count};
            if (mon_en && (obs !== prev)) begin
                prev = obs;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change: cyc=%0d usr_rst=%b link_up=%b qreq=%b cause=%b count=%0d",
                             cyc, usr_rst, link_up, quiesce_req, rst_cause, rst_count);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || obs !== {e.u, e.l, e.q, e.c, e.n}) begin
                        bad++;
                        $display("FAIL event: got cyc=%0d u=%b l=%b q=%b c=%b n=%0d want cyc=%0d u=%b l=%b q=%b c=%b n=%0d",
                                 cyc, usr_rst, link_up, quiesce_req, rst_cause, rst_count,
                                 e.cyc, e.u, e.l, e.q, e.c, e.n);
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge pld_clk);
        if (s_quiesce_req === 1'b1) s_q_seen = 1'b1;
    end

    initial begin
        int p, f0, a0, x, d0, r;
        srst = 1'b1; app_rstn = 1'b1; dl_up = 1'b1; ltssm = 5'h0F; quiesce_ack = 1'b0;
        s_srst = 1'b1; s_app_rstn = 1'b1; s_dl_up = 1'b1; s_ltssm = 5'h0F; s_quiesce_ack = 1'b0;
        mon_en = 1'b1;

        // power-up: reset values after first srst edge, release 18 edges after first capture
        push(1, 1, 0, 0, 2'b00, 8'd0);
        tick(4);
        srst = 1'b0; p = cyc + 1;
        push(p + 18, 0, 1, 0, 2'b00, 8'd0);
        tick_to(p + 20);

        // ack outside QUIESCE must produce no output change
        quiesce_ack = 1'b1; tick(1); quiesce_ack = 1'b0; tick(3);

        // LTSSM fault
        ltssm = 5'h10; f0 = cyc + 1;
`ifdef PCIE_APP_RST_QUIESCE_EN
        push(f0 + 1, 0, 0, 1, 2'b10, 8'd1);
        tick(1); ltssm = 5'h0F;
        tick(20); quiesce_ack = 1'b1; a0 = cyc + 1;
        tick(1); quiesce_ack = 1'b0;
        push(a0 + 1, 1, 0, 0, 2'b10, 8'd1);
        push(a0 + 82, 0, 1, 0, 2'b10, 8'd1);
        tick_to(a0 + 85);
`else
        push(f0 + 1, 1, 0, 0, 2'b10, 8'd1);
        tick(5); ltssm = 5'h0F;
        push(f0 + 82, 0, 1, 0, 2'b10, 8'd1);
        tick_to(f0 + 85);
`endif

        // app_rstn fault path, then a one-cycle dl_up glitch in DEBOUNCE
`ifdef PCIE_APP_RST_QUIESCE_EN
        dl_up = 1'b0; f0 = cyc + 1;
        push(f0 + 1, 0, 0, 1, 2'b10, 8'd2);
        tick(1); dl_up = 1'b1;
        tick(3); app_rstn = 1'b0; x = cyc + 1;
        push(x + 1, 1, 0, 0, 2'b10, 8'd2);
        tick(1); app_rstn = 1'b1;
        d0 = x + 66;
`else
        app_rstn = 1'b0; f0 = cyc + 1;
        push(f0 + 1, 1, 0, 0, 2'b01, 8'd2);
        tick(1); app_rstn = 1'b1;
        d0 = f0 + 66;
`endif
        tick_to(d0 + 9); dl_up = 1'b0;
        tick(1); dl_up = 1'b1;
        r = d0 + 11;
        push(r + 17, 0, 1, 0, RSTN_CAUSE, 8'd2);
        tick_to(r + 20);

        // third fault, then srst while in HOLD
        ltssm = 5'h10; f0 = cyc + 1;
`ifdef PCIE_APP_RST_QUIESCE_EN
        push(f0 + 1, 0, 0, 1, 2'b10, 8'd3);
        push(f0 + 1 + 4096, 1, 0, 0, 2'b11, 8'd3);
        tick_to(f0 + 4096 + 3);
`else
        push(f0 + 1, 1, 0, 0, 2'b10, 8'd3);
        tick_to(f0 + 4);
`endif
        srst = 1'b1; ltssm = 5'h0F;
        push(cyc + 1, 1, 0, 0, 2'b00, 8'd0);
        tick(2); srst = 1'b0; p = cyc + 1;
        push(p + 18, 0, 1, 0, 2'b00, 8'd0);
        tick_to(p + 20);
        tick(5);
        chk("events_pending", exp_q.size(), 0);

        // saturation on the small instance
        s_srst = 1'b0;
        tick(6);
        chk("sat_link_up_initial", int'(s_link_up), 1);
        for (int i = 0; i < 260; i++) begin
            s_dl_up = 1'b0; tick(1);
            s_dl_up = 1'b1; tick(7);
            if (i == 99) chk("sat_count_100", int'(s_rst_count), 100);
        end
        chk("sat_count_255", int'(s_rst_count), 255);
        chk("sat_link_up_final", int'(s_link_up), 1);
        chk("sat_cause", int'(s_rst_cause), int'(SAT_CAUSE));
        chk("sat_qreq_seen", int'(s_q_seen), SAT_QSEEN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
